// File: rtl/alu_ctrl_pkg.sv
// Shared ALU control definitions: opcode encodings, arbiter FSM states and
// the legal-opcode test used when flagging unsupported operations.
package alu_ctrl_pkg;

    localparam logic [3:0] OP_ADD  = 4'b0010;
    localparam logic [3:0] OP_CBZ  = 4'b0111;
    localparam logic [3:0] OP_SUB  = 4'b1010;
    localparam logic [3:0] OP_AND  = 4'b0110;
    localparam logic [3:0] OP_OR   = 4'b0100;
    localparam logic [3:0] OP_XOR  = 4'b1001;
    localparam logic [3:0] OP_NOR  = 4'b0101;
    localparam logic [3:0] OP_NAND = 4'b1100;
    localparam logic [3:0] OP_MOV  = 4'b1101;
    localparam logic [3:0] OP_NOP  = 4'b0000;

    typedef logic [1:0] state_t;

    localparam state_t ST_IDLE = 2'd0;
    localparam state_t ST_EXEC = 2'd1;
    localparam state_t ST_CAPT = 2'd2;
    localparam state_t ST_RESP = 2'd3;

    function automatic logic is_legal_opcode(input logic [3:0] op);
        case (op)
            OP_ADD, OP_CBZ, OP_SUB, OP_AND, OP_OR,
            OP_XOR, OP_NOR, OP_NAND, OP_MOV: is_legal_opcode = 1'b1;
            default:                         is_legal_opcode = 1'b0;
        endcase
    endfunction

endpackage

// File: rtl/rr_arbiter.sv
// Combinational round-robin pick: the first set bit of valid at or above
// pointer (wrapping) wins, reported both one-hot and as an index.
module rr_arbiter #(
    parameter int N_REQ = 2,
    parameter int IDX_W = 1
) (
    input  logic [N_REQ-1:0] valid,
    input  logic [IDX_W-1:0] pointer,
    output logic [N_REQ-1:0] grant,
    output logic [IDX_W-1:0] grantIdx,
    output logic             anyValid
);

    logic [IDX_W-1:0] cand;

    always_comb begin
        grant    = '0;
        grantIdx = '0;
        anyValid = 1'b0;
        cand     = pointer;
        for (int k = 0; k < N_REQ; k++) begin
            if (!anyValid && valid[cand]) begin
                grant[cand] = 1'b1;
                grantIdx    = cand;
                anyValid    = 1'b1;
            end
            cand = (cand == IDX_W'(N_REQ - 1)) ? '0 : cand + 1'b1;
        end
    end

endmodule

// File: rtl/alu_arbiter.sv
// Round-robin front end that shares one registered ALU between N_REQ
// requesters, one operation in flight, response held until accepted.
module alu_arbiter
    import alu_ctrl_pkg::*;
#(
    parameter int N_REQ = 2,
    parameter int WIDTH = 32
) (
    input  logic                   clock,
    input  logic                   reset_n,
    input  logic [N_REQ-1:0]       req_valid,
    output logic [N_REQ-1:0]       req_ready,
    input  logic [4*N_REQ-1:0]     req_opcode,
    input  logic [WIDTH*N_REQ-1:0] req_in_one,
    input  logic [WIDTH*N_REQ-1:0] req_in_two,
    output logic [N_REQ-1:0]       rsp_valid,
    input  logic [N_REQ-1:0]       rsp_ready,
    output logic [WIDTH-1:0]       rsp_result,
    output logic                   rsp_zero,
    output logic                   rsp_illegal,
    output logic [WIDTH-1:0]       alu_in_one,
    output logic [WIDTH-1:0]       alu_in_two,
    output logic [3:0]             alu_opcode,
    input  logic [WIDTH-1:0]       alu_result,
    input  logic                   alu_zero,
    output logic                   busy
);

    localparam int IDX_W = (N_REQ > 1) ? $clog2(N_REQ) : 1;

    state_t           state;
    logic [IDX_W-1:0] rrPtr;
    logic [IDX_W-1:0] grantIdx;
    logic             illegalExec;

    logic [N_REQ-1:0] arbGrant;
    logic [IDX_W-1:0] arbIdx;
    logic             arbAny;
    logic             accept;
    logic             rspDone;

    logic [3:0]       reqOp  [N_REQ];
    logic [WIDTH-1:0] reqOne [N_REQ];
    logic [WIDTH-1:0] reqTwo [N_REQ];

    for (genvar g = 0; g < N_REQ; g++) begin : g_unpack
        assign reqOp[g]  = req_opcode[4*g +: 4];
        assign reqOne[g] = req_in_one[WIDTH*g +: WIDTH];
        assign reqTwo[g] = req_in_two[WIDTH*g +: WIDTH];
    end

    rr_arbiter #(
        .N_REQ (N_REQ),
        .IDX_W (IDX_W)
    ) u_rr (
        .valid    (req_valid),
        .pointer  (rrPtr),
        .grant    (arbGrant),
        .grantIdx (arbIdx),
        .anyValid (arbAny)
    );

    // Grants are only offered while idle, so nothing is accepted during the
    // cycle a response completes.
    assign req_ready = (state == ST_IDLE) ? arbGrant : '0;
    assign accept    = (state == ST_IDLE) && arbAny;
    assign rspDone   = (state == ST_RESP) && rsp_ready[grantIdx];
    assign busy      = (state != ST_IDLE);

    always_comb begin
        rsp_valid = '0;
        if (state == ST_RESP) begin
            rsp_valid[grantIdx] = 1'b1;
        end
    end

    always_ff @(posedge clock) begin
        if (!reset_n) begin
            state       <= ST_IDLE;
            rrPtr       <= '0;
            grantIdx    <= '0;
            illegalExec <= 1'b0;
            alu_in_one  <= '0;
            alu_in_two  <= '0;
            alu_opcode  <= OP_NOP;
            rsp_result  <= '0;
            rsp_zero    <= 1'b0;
            rsp_illegal <= 1'b0;
        end else begin
            case (state)
                ST_IDLE: begin
                    if (accept) begin
                        alu_in_one <= reqOne[arbIdx];
                        alu_in_two <= reqTwo[arbIdx];
                        alu_opcode <= reqOp[arbIdx];
                        grantIdx   <= arbIdx;
                        rrPtr      <= (arbIdx == IDX_W'(N_REQ - 1)) ? '0 : arbIdx + 1'b1;
                        state      <= ST_EXEC;
                    end
                end
                // ALU samples alu_* at the end of this cycle; illegal ops still issue.
                ST_EXEC: begin
                    illegalExec <= !is_legal_opcode(alu_opcode);
                    state       <= ST_CAPT;
                end
                ST_CAPT: begin
                    rsp_result  <= alu_result;
                    rsp_zero    <= alu_zero;
                    rsp_illegal <= illegalExec;
                    state       <= ST_RESP;
                end
                ST_RESP: begin
                    if (rspDone) begin
                        state <= ST_IDLE;
                    end
                end
                default: state <= ST_IDLE;
            endcase
        end
    end

endmodule

// File: tb/tb_alu_arbiter.sv
// Directed plus randomized bench for alu_arbiter with a behavioural ALU and
// a round-robin reference model.
module tb_alu_arbiter;

    localparam int N_REQ = 2;
    localparam int WIDTH = 32;

    logic                   clock = 1'b0;
    logic                   reset_n;
    logic [N_REQ-1:0]       req_valid;
    logic [N_REQ-1:0]       req_ready;
    logic [4*N_REQ-1:0]     req_opcode;
    logic [WIDTH*N_REQ-1:0] req_in_one;
    logic [WIDTH*N_REQ-1:0] req_in_two;
    logic [N_REQ-1:0]       rsp_valid;
    logic [N_REQ-1:0]       rsp_ready;
    logic [WIDTH-1:0]       rsp_result;
    logic                   rsp_zero;
    logic                   rsp_illegal;
    logic [WIDTH-1:0]       alu_in_one;
    logic [WIDTH-1:0]       alu_in_two;
    logic [3:0]             alu_opcode;
    logic [WIDTH-1:0]       alu_result = '0;
    logic                   alu_zero = 1'b0;
    logic                   busy;

    int errors = 0;
    int checks = 0;
    int modelPtr = 0;

    logic [3:0]  pOp [N_REQ];
    logic [31:0] pA  [N_REQ];
    logic [31:0] pB  [N_REQ];
    logic [3:0]  opList [10] = '{4'b0010, 4'b0111, 4'b1010, 4'b0110, 4'b0100,
                                 4'b1001, 4'b0101, 4'b1100, 4'b1101, 4'b1111};
    logic [31:0] expQ [$];

    alu_arbiter #(.N_REQ(N_REQ), .WIDTH(WIDTH)) dut (
        .clock       (clock),
        .reset_n     (reset_n),
        .req_valid   (req_valid),
        .req_ready   (req_ready),
        .req_opcode  (req_opcode),
        .req_in_one  (req_in_one),
        .req_in_two  (req_in_two),
        .rsp_valid   (rsp_valid),
        .rsp_ready   (rsp_ready),
        .rsp_result  (rsp_result),
        .rsp_zero    (rsp_zero),
        .rsp_illegal (rsp_illegal),
        .alu_in_one  (alu_in_one),
        .alu_in_two  (alu_in_two),
        .alu_opcode  (alu_opcode),
        .alu_result  (alu_result),
        .alu_zero    (alu_zero),
        .busy        (busy)
    );

    always #5 clock = ~clock;

    function automatic logic [31:0] aluRef(input logic [3:0] op, input logic [31:0] a, input logic [31:0] b);
        case (op)
            4'b0010: return a + b;
            4'b0111: return (a == 0) ? 32'd1 : 32'd0;
            4'b1010: return a - b;
            4'b0110: return a & b;
            4'b0100: return a | b;
            4'b1001: return a ^ b;
            4'b0101: return ~(a | b);
            4'b1100: return ~(a & b);
            4'b1101: return b;
            default: return 32'd0;
        endcase
    endfunction

    // Registered ALU stand-in: one clock from operands to result.
    always @(posedge clock) begin
        alu_result <= aluRef(alu_opcode, alu_in_one, alu_in_two);
        alu_zero   <= (alu_in_two == 0);
    end

    function automatic logic isLegal(input logic [3:0] op);
        for (int i = 0; i < 9; i++) if (opList[i] == op) return 1'b1;
        return 1'b0;
    endfunction

    function automatic int expWinner();
        for (int k = 0; k < N_REQ; k++) begin
            if (req_valid[(modelPtr + k) % N_REQ]) return (modelPtr + k) % N_REQ;
        end
        return 0;
    endfunction

    task automatic check(input string tag, input logic [31:0] obs, input logic [31:0] exp);
        checks++;
        assert (obs === exp) else begin
            errors++;
            $error("FAIL %s: observed %h expected %h", tag, obs, exp);
        end
    endtask

    task automatic tick();
        @(posedge clock);
        #1;
    endtask

    task automatic load(input int r, input logic [3:0] op, input logic [31:0] a, input logic [31:0] b);
        pOp[r] = op;
        pA[r]  = a;
        pB[r]  = b;
        req_opcode[4*r +: 4]         = op;
        req_in_one[WIDTH*r +: WIDTH] = a;
        req_in_two[WIDTH*r +: WIDTH] = b;
    endtask

    task automatic doReset();
        reset_n   = 1'b0;
        req_valid = '0;
        rsp_ready = '0;
        tick();
        reset_n  = 1'b1;
        modelPtr = 0;
    endtask

    // Serves the model's next winner among the currently valid requesters.
    task automatic serveOne(input int hold);
        int w;
        int n;
        logic [31:0] expRes;
        #1;
        w = expWinner();
        n = 0;
        while (req_ready == '0 && n < 20) begin
            tick();
            n++;
        end
        check("grant", 32'(req_ready), 32'(1 << w));
        tick();
        req_valid[w] = 1'b0;
        modelPtr = (w + 1) % N_REQ;
        expRes = aluRef(pOp[w], pA[w], pB[w]);
        n = 1;
        while (rsp_valid == '0 && n < 10) begin
            tick();
            n++;
        end
        check("latency", 32'(n), 32'd3);
        check("rsp_valid", 32'(rsp_valid), 32'(1 << w));
        check("result", rsp_result, expRes);
        check("zero", 32'(rsp_zero), 32'(pB[w] == 0));
        check("illegal", 32'(rsp_illegal), 32'(!isLegal(pOp[w])));
        check("alu_opcode", 32'(alu_opcode), 32'(pOp[w]));
        for (int i = 0; i < hold; i++) begin
            rsp_ready = ~N_REQ'(1 << w);
            tick();
            check("hold valid", 32'(rsp_valid), 32'(1 << w));
            check("hold result", rsp_result, expRes);
            check("hold req_ready", 32'(req_ready), 32'd0);
        end
        rsp_ready = N_REQ'(1 << w);
        tick();
        rsp_ready = '0;
        check("rsp drop", 32'(rsp_valid), 32'd0);
        check("busy after", 32'(busy), 32'd0);
    endtask

    initial begin
        int n;
        int got;
        int sent;
        int lastAcc;
        int cyc;
        logic accepting;
        logic [1:0] mask;

        req_opcode = '0;
        req_in_one = '0;
        req_in_two = '0;
        doReset();
        tick();
        check("reset req_ready", 32'(req_ready), 32'd0);
        check("reset rsp_valid", 32'(rsp_valid), 32'd0);
        check("reset busy", 32'(busy), 32'd0);
        check("reset alu_opcode", 32'(alu_opcode), 32'd0);
        check("reset alu_in_one", alu_in_one, 32'd0);
        check("reset rsp_result", rsp_result, 32'd0);

        // single ADD
        load(0, 4'b0010, 32'd5, 32'd7);
        req_valid[0] = 1'b1;
        serveOne(0);
        check("add 5+7", rsp_result, 32'd12);

        // simultaneous requests from pointer 0
        doReset();
        load(0, 4'b1010, 32'd10, 32'd3);
        load(1, 4'b0110, 32'h0000_00F0, 32'h0000_003C);
        req_valid = 2'b11;
        serveOne(0);
        serveOne(0);
        load(0, opList[$urandom_range(0, 8)], $urandom, $urandom);
        req_valid[0] = 1'b1;
        serveOne(0);
        load(0, opList[$urandom_range(0, 8)], $urandom, $urandom);
        load(1, opList[$urandom_range(0, 8)], $urandom, $urandom);
        req_valid = 2'b11;
        check("pair winner model", 32'(expWinner()), 32'd1);
        serveOne(0);
        serveOne(0);

        // backpressure on req1 while req0 waits
        load(1, 4'b1101, $urandom, 32'hDEAD_BEEF);
        load(0, 4'b0100, $urandom, $urandom);
        req_valid = 2'b11;
        serveOne(5);
        serveOne(0);

        // zero / illegal / CBZ
        load(0, 4'b1111, 32'd9, 32'd0);
        req_valid[0] = 1'b1;
        serveOne(0);
        load(1, 4'b0111, 32'd0, 32'd5);
        req_valid[1] = 1'b1;
        serveOne(0);

        // reset while a response is pending
        load(0, 4'b0010, $urandom, $urandom);
        req_valid[0] = 1'b1;
        #1;
        n = 0;
        while (req_ready == '0 && n < 20) begin
            tick();
            n++;
        end
        tick();
        req_valid[0] = 1'b0;
        tick();
        tick();
        check("pre-reset rsp_valid", 32'(rsp_valid), 32'd1);
        reset_n = 1'b0;
        tick();
        reset_n = 1'b1;
        modelPtr = 0;
        check("mid-reset rsp_valid", 32'(rsp_valid), 32'd0);
        check("mid-reset busy", 32'(busy), 32'd0);
        check("mid-reset alu_opcode", 32'(alu_opcode), 32'd0);
        check("mid-reset rsp_result", rsp_result, 32'd0);
        tick();
        tick();
        check("no stale rsp", 32'(rsp_valid), 32'd0);
        load(0, 4'b1001, $urandom, $urandom);
        load(1, 4'b0101, $urandom, $urandom);
        req_valid = 2'b11;
        serveOne(0);
        serveOne(0);
        load(1, 4'b1100, $urandom, $urandom);
        req_valid[1] = 1'b1;
        serveOne(1);

        // random rounds
        for (int round = 0; round < 8; round++) begin
            mask = 2'($urandom_range(1, 3));
            for (int r = 0; r < N_REQ; r++) begin
                if (mask[r]) load(r, opList[$urandom_range(0, 9)], $urandom, ($urandom_range(0, 3) == 0) ? 32'd0 : $urandom);
            end
            req_valid = mask;
            while (req_valid != '0) serveOne($urandom_range(0, 2));
        end

        // back-to-back stream from req0
        rsp_ready = 2'b01;
        got = 0;
        sent = 0;
        lastAcc = -1;
        cyc = 0;
        load(0, opList[$urandom_range(0, 8)], $urandom, $urandom);
        req_valid[0] = 1'b1;
        #1;
        while (got < 8 && cyc < 120) begin
            if (rsp_valid != '0) begin
                check("stream rsp_valid", 32'(rsp_valid), 32'd1);
                if (expQ.size() > 0) check("stream result", rsp_result, expQ.pop_front());
                else check("stream extra rsp", 32'(rsp_valid), 32'd0);
                got++;
            end
            accepting = req_valid[0] && req_ready[0];
            if (accepting) begin
                if (lastAcc >= 0) check("stream interval", 32'(cyc - lastAcc), 32'd4);
                lastAcc = cyc;
                expQ.push_back(aluRef(pOp[0], pA[0], pB[0]));
                sent++;
            end
            tick();
            cyc++;
            if (accepting) begin
                if (sent < 8) load(0, opList[$urandom_range(0, 8)], $urandom, $urandom);
                else req_valid[0] = 1'b0;
            end
        end
        check("stream count", 32'(got), 32'd8);
        check("stream sent", 32'(sent), 32'd8);
        rsp_ready = '0;

        $display("Result: errors=%0d of %0d checks", errors, checks);
        $finish;
    end

endmodule
